// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the single-step helper used by the unrolled beat generator.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_N = 64;

  // Default polynomial: 8-bit state, taps on bits 0 and 1, seeded with 1.
  localparam int unsigned LFSR_N_DEFAULT     = 8;
  localparam logic [7:0]  LFSR_TAPS_DEFAULT  = 8'h03;
  localparam logic [7:0]  LFSR_START_DEFAULT = 8'h01;

  typedef struct packed {
    logic [LFSR_MAX_N-1:0] state;
    logic                  out_bit;
  } lfsr_step_t;

  // One Fibonacci step on an n-bit state held in the low bits of a 64-bit word.
  function automatic lfsr_step_t lfsr_step(input logic [LFSR_MAX_N-1:0] state,
                                           input logic [LFSR_MAX_N-1:0] taps,
                                           input int unsigned           n);
    lfsr_step_t r;
    r.out_bit          = state[0];
    r.state            = state >> 1;
    r.state[6'(n - 1)] = ^(state & taps);
    return r;
  endfunction

endpackage

// File: rtl/lfsr_unroll.sv
// Combinational W-step LFSR unroll: beat bits (LSB first in time) and the resulting state.
module lfsr_unroll
  import lfsr_pkg::*;
#(
  parameter int unsigned N    = LFSR_N_DEFAULT,
  parameter int unsigned W    = 8,
  parameter logic [N-1:0] TAPS = N'(LFSR_TAPS_DEFAULT)
) (
  input  logic [N-1:0] cur_state,
  output logic [W-1:0] beat_bits,
  output logic [N-1:0] end_state
);

  lfsr_step_t            step_r;
  logic [LFSR_MAX_N-1:0] walk;

  always_comb begin
    walk      = LFSR_MAX_N'(cur_state);
    beat_bits = '0;
    step_r    = '0;
    for (int k = 0; k < int'(W); k++) begin
      step_r       = lfsr_step(walk, LFSR_MAX_N'(TAPS), N);
      beat_bits[k] = step_r.out_bit;
      walk         = step_r.state;
    end
    end_state = walk[N-1:0];
  end

endmodule

// File: rtl/lfsr_stream.sv
// Valid/ready LFSR pattern source with seed load and accepted-beat counter.
// Optional zero-state recovery with lockup pulse when LFSR_LOCKUP_RECOVER_EN is defined.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int unsigned  N           = LFSR_N_DEFAULT,
  parameter int unsigned  W           = 8,
  parameter logic [N-1:0] START_VALUE = N'(LFSR_START_DEFAULT),
  parameter logic [N-1:0] TAPS        = N'(LFSR_TAPS_DEFAULT),
  parameter int unsigned  CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic             seed_valid_i,
  input  logic [N-1:0]     seed_i,
  output logic [W-1:0]     data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] beat_cnt_o,
  output logic             lockup_o
);

  logic [N-1:0]     state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             adv_c;
  logic             hs_c;
  logic             recover_c;
  logic [N-1:0]     gen_src;
  logic [N-1:0]     gen_end;
  logic [W-1:0]     gen_bits;

  // Handshake qualification; a seed load always wins over generation.
  always_comb begin
    adv_c = en_i && (!valid_q || ready_i) && !seed_valid_i;
    hs_c  = valid_q && ready_i;
`ifdef LFSR_LOCKUP_RECOVER_EN
    recover_c = adv_c && (state_q == '0);
`else
    recover_c = 1'b0;
`endif
    gen_src = recover_c ? START_VALUE : state_q;
  end

  lfsr_unroll #(
    .N    (N),
    .W    (W),
    .TAPS (TAPS)
  ) u_unroll (
    .cur_state (gen_src),
    .beat_bits (gen_bits),
    .end_state (gen_end)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = hs_c ? cnt_q + CNT_W'(1) : cnt_q;
    if (seed_valid_i) begin
      state_d = seed_i;
      data_d  = '0;
      valid_d = 1'b0;
    end else if (adv_c) begin
      state_d = gen_end;
      data_d  = gen_bits;
      valid_d = 1'b1;
    end else if (hs_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= START_VALUE;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lockup_q;

  // Pulses alongside the beat that was regenerated from START_VALUE.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= recover_c;
    end
  end

  assign lockup_o = lockup_q;
`else
  assign lockup_o = 1'b0;
`endif

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign beat_cnt_o = cnt_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench for lfsr_stream: directed scenarios plus randomized en/ready/seed traffic.
module tb_lfsr_stream;

  localparam int unsigned    TN     = 8;
  localparam int unsigned    TW     = 8;
  localparam int unsigned    TCNT   = 4;
  localparam logic [TN-1:0]  TTAPS  = 8'h03;
  localparam logic [TN-1:0]  TSTART = 8'h01;

  logic            clk_i        = 1'b0;
  logic            reset_ni     = 1'b0;
  logic            en_i         = 1'b0;
  logic            seed_valid_i = 1'b0;
  logic [TN-1:0]   seed_i       = '0;
  logic            ready_i      = 1'b0;
  logic [TW-1:0]   data_o;
  logic            valid_o;
  logic [TCNT-1:0] beat_cnt_o;
  logic            lockup_o;

  lfsr_stream #(
    .N           (TN),
    .W           (TW),
    .START_VALUE (TSTART),
    .TAPS        (TTAPS),
    .CNT_W       (TCNT)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .en_i         (en_i),
    .seed_valid_i (seed_valid_i),
    .seed_i       (seed_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .beat_cnt_o   (beat_cnt_o),
    .lockup_o     (lockup_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [TW-1:0] data;
    bit            lock;
  } chunk_t;

  chunk_t      exp_q[$];
  int unsigned gen_state;
  int unsigned exp_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_seen  = 0;
  bit          prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sequence: successive W-bit slices of the serial LFSR output from the current seed.
  task automatic refill();
    while (exp_q.size() < 4) begin
      chunk_t      c;
      int unsigned fb;
      c.data = '0;
      c.lock = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (gen_state == 0) begin
        gen_state = 32'(TSTART);
        c.lock    = 1'b1;
      end
`endif
      for (int k = 0; k < int'(TW); k++) begin
        c.data[k] = (gen_state % 2) == 1;
        fb        = $countones(gen_state & 32'(TTAPS)) % 2;
        gen_state = (gen_state >> 1) + fb * (32'd1 << (TN - 1));
      end
      exp_q.push_back(c);
    end
  endtask

  task automatic restart(input int unsigned s);
    exp_q.delete();
    gen_state = s;
    refill();
  endtask

  // Advance one clock; a seed presented during that cycle restarts the expected sequence.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (seed_valid_i) restart(32'(seed_i));
    refill();
  endtask

  // Monitor: compare every accepted beat and the counter, mid-cycle.
  always @(negedge clk_i) begin
    if (!reset_ni) begin
      exp_cnt    = 0;
      prev_valid = 1'b0;
    end else begin
      chk("beat_cnt", 64'(beat_cnt_o), 64'(exp_cnt));
`ifdef LFSR_LOCKUP_RECOVER_EN
      chk("lockup", 64'(lockup_o),
          64'((valid_o && !prev_valid && exp_q.size() > 0) ? exp_q[0].lock : 1'b0));
`else
      chk("lockup_zero", 64'(lockup_o), 64'd0);
`endif
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("beat_queue_empty", 64'd1, 64'd0);
        end else begin
          chunk_t c;
          c = exp_q.pop_front();
          chk("beat_data", 64'(data_o), 64'(c.data));
        end
        exp_cnt = (exp_cnt + 1) % (32'd1 << TCNT);
        hs_seen++;
      end
      prev_valid = valid_o;
    end
  end

  initial begin
    restart(32'(TSTART));
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_cnt", 64'(beat_cnt_o), 64'd0);
    chk("rst_lockup", 64'(lockup_o), 64'd0);
    reset_ni = 1'b1;

    // First beat one cycle after enable, then held under backpressure.
    en_i    = 1'b1;
    ready_i = 1'b0;
    tick();
    chk("first_valid", 64'(valid_o), 64'd1);
    chk("first_data", 64'(data_o), 64'h01);
    repeat (5) begin
      tick();
      chk("hold_valid", 64'(valid_o), 64'd1);
      chk("hold_data", 64'(data_o), 64'h01);
    end
    ready_i = 1'b1;
    tick();
    chk("second_data", 64'(data_o), 64'h81);

    // Seed load discards the pending beat.
    ready_i      = 1'b0;
    seed_valid_i = 1'b1;
    seed_i       = 8'h81;
    tick();
    chk("seed_valid_drop", 64'(valid_o), 64'd0);
    chk("seed_data_clear", 64'(data_o), 64'd0);
    seed_valid_i = 1'b0;
    ready_i      = 1'b1;
    tick();
    chk("seed_beat_valid", 64'(valid_o), 64'd1);
    chk("seed_beat_data", 64'(data_o), 64'h81);

    // Asynchronous reset in the middle of a streaming cycle.
    repeat (3) tick();
    #2;
    reset_ni = 1'b0;
    restart(32'(TSTART));
    #1;
    chk("async_rst_data", 64'(data_o), 64'd0);
    chk("async_rst_valid", 64'(valid_o), 64'd0);
    chk("async_rst_cnt", 64'(beat_cnt_o), 64'd0);
    chk("async_rst_lockup", 64'(lockup_o), 64'd0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;

    // 17 handshakes on a 4-bit counter wrap to 1.
    repeat (18) tick();
    chk("cnt_wrap", 64'(beat_cnt_o), 64'd1);

    // All-zero seed.
    seed_valid_i = 1'b1;
    seed_i       = '0;
    tick();
    seed_valid_i = 1'b0;
    tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("zero_seed_lockup", 64'(lockup_o), 64'd1);
    chk("zero_seed_data", 64'(data_o), 64'h01);
    tick();
    chk("zero_seed_lockup_once", 64'(lockup_o), 64'd0);
    chk("zero_seed_next", 64'(data_o), 64'h81);
`else
    repeat (4) begin
      chk("zero_seed_valid", 64'(valid_o), 64'd1);
      chk("zero_seed_data", 64'(data_o), 64'd0);
      chk("zero_seed_lockup", 64'(lockup_o), 64'd0);
      tick();
    end
`endif

    // Randomized enable, backpressure and occasional seed loads.
    repeat (1500) begin
      en_i         = ($urandom_range(0, 9) < 8);
      ready_i      = ($urandom_range(0, 9) < 7);
      seed_valid_i = ($urandom_range(0, 39) == 0);
      seed_i       = ($urandom_range(0, 3) == 0) ? '0 : TN'($urandom);
      tick();
    end

    en_i         = 1'b0;
    seed_valid_i = 1'b0;
    ready_i      = 1'b1;
    repeat (3) tick();
    chk("handshakes_seen", 64'(hs_seen > 200), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
